// File: rtl/wave_addr_gen.sv
// Phase-accumulator address generator for waveform playback.
// Emits the top ADDR_W accumulator bits as a memory address, with wrap and burst-completion status.
module wave_addr_gen #(
  parameter int ACC_W   = 24,
  parameter int ADDR_W  = 10,
  parameter int BURST_W = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               EN_in,
  input  logic               Reset_BAC,
  input  logic               Pulse_in,
  input  logic [ACC_W-1:0]   Phase_inc,
  input  logic [BURST_W-1:0] Burst_len,
  output logic [ADDR_W-1:0]  Addr,
  output logic               Addr_valid,
  output logic               Wrap,
  output logic               Busy,
  output logic               Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [BURST_W-1:0] rem_q;
  logic               valid_q;
  logic               wrap_q;

  logic [ACC_W:0]     sum_d;
  logic               carry_d;
  logic               trigger_d;
  logic               last_d;

  // NOTE: every always_comb output is assigned unconditionally, so no latch can be inferred.
  always_comb begin
    sum_d     = {1'b0, acc_q} + {1'b0, Phase_inc};
    carry_d   = sum_d[ACC_W];
    trigger_d = !Pulse_in && EN_in;
    last_d    = carry_d && (rem_q == BURST_W'(1));
  end

  // Reset_BAC outranks a trigger; a trigger restarts playback from any state.
  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset || !Reset_BAC) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (trigger_d) begin
      state_q <= S_RUN;
      acc_q   <= '0;
      rem_q   <= Burst_len;
      valid_q <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (!EN_in) begin
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
          end else if (last_d) begin
            state_q <= S_DONE;
            acc_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b1;
          end else begin
            acc_q   <= sum_d[ACC_W-1:0];
            valid_q <= 1'b1;
            wrap_q  <= carry_d;
            // rem_q == 0 means continuous playback; it is never counted down
            if (carry_d && rem_q != '0) begin
              rem_q <= rem_q - BURST_W'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          acc_q   <= '0;
          rem_q   <= '0;
          valid_q <= 1'b0;
          wrap_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Addr       = acc_q[ACC_W-1 -: ADDR_W];
  assign Addr_valid = valid_q;
  assign Wrap       = wrap_q;
  assign Busy       = (state_q == S_RUN);
  assign Done       = (state_q == S_DONE);

endmodule

// File: tb/tb_wave_addr_gen.sv
// Self-checking bench for wave_addr_gen: directed playback scenarios, then random stimulus,
// all compared every cycle against a period-counting arithmetic model.
module tb_wave_addr_gen;

  localparam int ACC_W   = 24;
  localparam int ADDR_W  = 10;
  localparam int BURST_W = 8;
  localparam longint ACC_MOD = 64'd1 << ACC_W;

  logic               Clock = 1'b0;
  logic               Reset;
  logic               EN_in;
  logic               Reset_BAC;
  logic               Pulse_in;
  logic [ACC_W-1:0]   Phase_inc;
  logic [BURST_W-1:0] Burst_len;
  logic [ADDR_W-1:0]  Addr;
  logic               Addr_valid;
  logic               Wrap;
  logic               Busy;
  logic               Done;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  wave_addr_gen #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .EN_in      (EN_in),
    .Reset_BAC  (Reset_BAC),
    .Pulse_in   (Pulse_in),
    .Phase_inc  (Phase_inc),
    .Burst_len  (Burst_len),
    .Addr       (Addr),
    .Addr_valid (Addr_valid),
    .Wrap       (Wrap),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Playback is modelled as a phase in [0, 2^ACC_W) plus a count of completed periods
  // against the burst target captured at trigger time.
  longint m_phase   = 0;
  longint m_sum;
  int     m_target  = 0;
  int     m_periods = 0;
  bit     m_playing = 0;
  bit     m_done    = 0;
  bit     m_valid   = 0;
  bit     m_wrap    = 0;

  always @(posedge Clock) begin
    m_done = 0;
    if (Reset || !Reset_BAC) begin
      m_phase = 0; m_playing = 0; m_valid = 0; m_wrap = 0; m_target = 0; m_periods = 0;
    end else if (!Pulse_in && EN_in) begin
      m_phase = 0; m_playing = 1; m_valid = 1; m_wrap = 0;
      m_target = int'(Burst_len); m_periods = 0;
    end else if (m_playing && EN_in) begin
      m_sum = m_phase + longint'(Phase_inc);
      m_wrap = (m_sum >= ACC_MOD);
      if (m_wrap) m_periods++;
      if (m_wrap && m_target != 0 && m_periods == m_target) begin
        m_playing = 0; m_done = 1; m_phase = 0; m_valid = 0;
      end else begin
        m_phase = m_sum % ACC_MOD; m_valid = 1;
      end
    end else if (m_playing) begin
      m_valid = 0; m_wrap = 0;
    end else begin
      m_phase = 0; m_valid = 0; m_wrap = 0;
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      check("model_addr",  32'(Addr),       32'(m_phase >> (ACC_W - ADDR_W)));
      check("model_valid", 32'(Addr_valid), 32'(m_valid));
      check("model_wrap",  32'(Wrap),       32'(m_wrap));
      check("model_busy",  32'(Busy),       32'(m_playing));
      check("model_done",  32'(Done),       32'(m_done));
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge Clock);
  endtask

  task automatic trigger();
    Pulse_in = 1'b0;
    tick();
    Pulse_in = 1'b1;
  endtask

  initial begin
    // 1: reset with random inputs, then idle with no trigger
    Reset     = 1'b1;
    EN_in     = 1'($urandom);
    Reset_BAC = 1'($urandom);
    Pulse_in  = 1'($urandom);
    Phase_inc = ACC_W'($urandom);
    Burst_len = BURST_W'($urandom);
    tick();
    chk_en = 1'b1;
    Pulse_in  = 1'($urandom);
    Phase_inc = ACC_W'($urandom);
    tick();
    check("rst_addr",  32'(Addr), 0);
    check("rst_valid", 32'(Addr_valid), 0);
    check("rst_wrap",  32'(Wrap), 0);
    check("rst_busy",  32'(Busy), 0);
    check("rst_done",  32'(Done), 0);
    Reset = 1'b0; EN_in = 1'b1; Reset_BAC = 1'b1; Pulse_in = 1'b1;
    tick(6);
    check("idle_addr", 32'(Addr), 0);
    check("idle_busy", 32'(Busy), 0);

    // 2 + 4: continuous mode, step of one address per advance, pause at 100
    Phase_inc = 24'h004000; Burst_len = 8'd0;
    trigger();
    check("t2_first_addr",  32'(Addr), 0);
    check("t2_first_valid", 32'(Addr_valid), 1);
    check("t2_first_busy",  32'(Busy), 1);
    tick(100);
    check("t4_addr100", 32'(Addr), 100);
    EN_in = 1'b0;
    tick(5);
    check("t4_pause_addr",  32'(Addr), 100);
    check("t4_pause_valid", 32'(Addr_valid), 0);
    check("t4_pause_busy",  32'(Busy), 1);
    EN_in = 1'b1;
    tick();
    check("t4_resume_addr", 32'(Addr), 101);
    tick(922);
    check("t2_addr1023", 32'(Addr), 1023);
    check("t2_nowrap",   32'(Wrap), 0);
    tick();
    check("t2_wrap_addr", 32'(Addr), 0);
    check("t2_wrap",      32'(Wrap), 1);
    check("t2_wrap_busy", 32'(Busy), 1);
    check("t2_no_done",   32'(Done), 0);

    // 5: retrigger at 300, then trigger together with Reset_BAC
    tick(300);
    check("t5_addr300", 32'(Addr), 300);
    trigger();
    check("t5_retrig_addr",  32'(Addr), 0);
    check("t5_retrig_valid", 32'(Addr_valid), 1);
    tick(300);
    Pulse_in = 1'b0; Reset_BAC = 1'b0;
    tick();
    Pulse_in = 1'b1; Reset_BAC = 1'b1;
    check("t5_bac_addr", 32'(Addr), 0);
    check("t5_bac_busy", 32'(Busy), 0);
    tick(3);
    check("t5_no_restart", 32'(Busy), 0);

    // 3: two-period burst, 16 advances per period
    Phase_inc = 24'h100000; Burst_len = 8'd2;
    trigger();
    tick();
    check("t3_step64", 32'(Addr), 64);
    tick(14);
    check("t3_addr960", 32'(Addr), 960);
    tick();
    check("t3_wrap16",      32'(Wrap), 1);
    check("t3_wrap16_busy", 32'(Busy), 1);
    tick(16);
    check("t3_wrap32", 32'(Wrap), 1);
    check("t3_done",   32'(Done), 1);
    check("t3_busy0",  32'(Busy), 0);
    check("t3_addr0",  32'(Addr), 0);
    tick();
    check("t3_done_pulse", 32'(Done), 0);
    check("t3_after_busy", 32'(Busy), 0);

    // 6: Reset_BAC mid-burst gives no Done; next trigger plays a full burst
    trigger();
    tick(20);
    Reset_BAC = 1'b0;
    tick();
    Reset_BAC = 1'b1;
    check("t6_bac_busy", 32'(Busy), 0);
    check("t6_bac_done", 32'(Done), 0);
    tick(2);
    trigger();
    tick(31);
    check("t6_full_burst_busy", 32'(Busy), 1);
    tick();
    check("t6_full_burst_done", 32'(Done), 1);
    Burst_len = 8'd1;
    trigger();
    check("t6_trig_in_done_busy", 32'(Busy), 1);
    tick(16);
    check("t6_len1_done", 32'(Done), 1);

    // zero phase increment: address frozen, valid, no wrap or done
    Phase_inc = '0; Burst_len = 8'd1;
    trigger();
    tick(40);
    check("zero_inc_busy",  32'(Busy), 1);
    check("zero_inc_valid", 32'(Addr_valid), 1);

    // random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      Reset     = ($urandom_range(0, 299) == 0);
      Reset_BAC = ($urandom_range(0, 99) != 0);
      Pulse_in  = ($urandom_range(0, 39) != 0);
      EN_in     = ($urandom_range(0, 6) != 0);
      Burst_len = BURST_W'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       Phase_inc = '0;
          1:       Phase_inc = ACC_W'($urandom);
          default: Phase_inc = ACC_W'($urandom_range(1, 32'h0040_0000));
        endcase
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
